// File: rtl/hls_module_status_monitor.sv
// Per-channel activity monitor for the HLS ap_start/ap_ready/ap_done/ap_continue handshake.
// Accumulates saturating statistics over a measurement window and exposes them through a registered read port.
module hls_module_status_monitor #(
    parameter int unsigned      N_CH    = 10,
    parameter int unsigned      CNT_W   = 32,
    parameter logic [N_CH-1:0]  CONT_EN = {N_CH{1'b0}},
    localparam int unsigned     CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             finish,
    input  logic             clear,
    input  logic [N_CH-1:0]  ap_start,
    input  logic [N_CH-1:0]  ap_ready,
    input  logic [N_CH-1:0]  ap_done,
    input  logic [N_CH-1:0]  ap_continue,
    input  logic             rd_en,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [2:0]       rd_sel,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             active,
    output logic [N_CH-1:0]  ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q     [N_CH];
    state_t           state_nxt   [N_CH];
    logic [CNT_W-1:0] start_q     [N_CH];
    logic [CNT_W-1:0] start_nxt   [N_CH];
    logic [CNT_W-1:0] ready_q     [N_CH];
    logic [CNT_W-1:0] ready_nxt   [N_CH];
    logic [CNT_W-1:0] done_q      [N_CH];
    logic [CNT_W-1:0] done_nxt    [N_CH];
    logic [CNT_W-1:0] busy_q      [N_CH];
    logic [CNT_W-1:0] busy_nxt    [N_CH];
    logic [CNT_W-1:0] stall_q     [N_CH];
    logic [CNT_W-1:0] stall_nxt   [N_CH];
    logic [CNT_W-1:0] max_lat_q   [N_CH];
    logic [CNT_W-1:0] max_lat_nxt [N_CH];
    logic [CNT_W-1:0] lat_q       [N_CH];
    logic [CNT_W-1:0] lat_nxt     [N_CH];
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_nxt;
    logic             active_q;
    logic             active_nxt;
    logic             opened_q;
    logic             cont;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] rd_mux_c;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic full(input logic [CNT_W-1:0] v);
        return v == {CNT_W{1'b1}};
    endfunction

    assign active = active_q;
    assign ovf    = ovf_q;

    // State and statistics registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]   <= ST_IDLE;
                start_q[i]   <= '0;
                ready_q[i]   <= '0;
                done_q[i]    <= '0;
                busy_q[i]    <= '0;
                stall_q[i]   <= '0;
                max_lat_q[i] <= '0;
                lat_q[i]     <= '0;
            end
            ovf_q    <= '0;
            active_q <= 1'b0;
            opened_q <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state_q   <= state_nxt;
            start_q   <= start_nxt;
            ready_q   <= ready_nxt;
            done_q    <= done_nxt;
            busy_q    <= busy_nxt;
            stall_q   <= stall_nxt;
            max_lat_q <= max_lat_nxt;
            lat_q     <= lat_nxt;
            ovf_q     <= ovf_nxt;
            active_q  <= active_nxt;
            opened_q  <= 1'b1;
            rd_valid  <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux_c;
            end
        end
    end

    // Channel FSMs and counter updates; the window opens once after reset and on clear
    always_comb begin
        state_nxt   = state_q;
        start_nxt   = start_q;
        ready_nxt   = ready_q;
        done_nxt    = done_q;
        busy_nxt    = busy_q;
        stall_nxt   = stall_q;
        max_lat_nxt = max_lat_q;
        lat_nxt     = lat_q;
        ovf_nxt     = ovf_q;
        cont        = 1'b1;
        cand        = '0;
        active_nxt  = clear | (~finish & (active_q | ~opened_q));

        for (int i = 0; i < N_CH; i++) begin
            cont = ~CONT_EN[i] | ap_continue[i];
            cand = sat(lat_q[i]);
            case (state_q[i])
                ST_IDLE: begin
                    if (ap_start[i]) begin
                        lat_nxt[i] = CNT_W'(1);
                        if (active_q) begin
                            start_nxt[i] = sat(start_q[i]);
                            ovf_nxt[i]   = ovf_nxt[i] | full(start_q[i]);
                        end
                        if (ap_done[i]) begin
                            if (active_q) begin
                                done_nxt[i] = sat(done_q[i]);
                                ovf_nxt[i]  = ovf_nxt[i] | full(done_q[i]);
                                if (max_lat_q[i] < CNT_W'(1)) begin
                                    max_lat_nxt[i] = CNT_W'(1);
                                end
                            end
                            state_nxt[i] = cont ? ST_IDLE : ST_HOLD;
                        end else begin
                            state_nxt[i] = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    lat_nxt[i] = cand;
                    if (active_q) begin
                        busy_nxt[i] = sat(busy_q[i]);
                        ovf_nxt[i]  = ovf_nxt[i] | full(busy_q[i]) | full(lat_q[i]);
                    end
                    if (ap_done[i]) begin
                        if (active_q) begin
                            done_nxt[i] = sat(done_q[i]);
                            ovf_nxt[i]  = ovf_nxt[i] | full(done_q[i]);
                            if (cand > max_lat_q[i]) begin
                                max_lat_nxt[i] = cand;
                            end
                        end
                        state_nxt[i] = cont ? ST_IDLE : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ap_continue[i]) begin
                        state_nxt[i] = ST_IDLE;
                    end else if (active_q) begin
                        stall_nxt[i] = sat(stall_q[i]);
                        ovf_nxt[i]   = ovf_nxt[i] | full(stall_q[i]);
                    end
                end
                default: state_nxt[i] = ST_IDLE;
            endcase

            if (active_q && ap_ready[i]) begin
                ready_nxt[i] = sat(ready_q[i]);
                ovf_nxt[i]   = ovf_nxt[i] | full(ready_q[i]);
            end

            // clear wipes statistics but leaves the FSM tracking untouched
            if (clear) begin
                start_nxt[i]   = '0;
                ready_nxt[i]   = '0;
                done_nxt[i]    = '0;
                busy_nxt[i]    = '0;
                stall_nxt[i]   = '0;
                max_lat_nxt[i] = '0;
                ovf_nxt[i]     = 1'b0;
            end
        end
    end

    // Read mux taps the post-update values so a read reflects this cycle's events
    always_comb begin
        rd_mux_c = '0;
        if (32'(rd_ch) < N_CH) begin
            case (rd_sel)
                3'd0:    rd_mux_c = start_nxt[rd_ch];
                3'd1:    rd_mux_c = ready_nxt[rd_ch];
                3'd2:    rd_mux_c = done_nxt[rd_ch];
                3'd3:    rd_mux_c = busy_nxt[rd_ch];
                3'd4:    rd_mux_c = stall_nxt[rd_ch];
                3'd5:    rd_mux_c = max_lat_nxt[rd_ch];
                3'd6:    rd_mux_c = CNT_W'(state_nxt[rd_ch]);
                default: rd_mux_c = CNT_W'({ovf_nxt[rd_ch], active_nxt});
            endcase
        end
    end

endmodule

// File: tb/tb_hls_module_status_monitor.sv
// Directed bench for hls_module_status_monitor: a 4-channel 16-bit instance for the
// functional cases and a 5-channel 8-bit instance, fed the same stimulus, for saturation and range.
module tb_hls_module_status_monitor;

    logic        clock;
    logic        reset;
    logic        finish;
    logic        clear;
    logic [3:0]  ap_start;
    logic [3:0]  ap_ready;
    logic [3:0]  ap_done;
    logic [3:0]  ap_continue;
    logic        rd_en;
    logic [2:0]  rd_ch;
    logic [2:0]  rd_sel;

    logic        rd_valid16;
    logic [15:0] rd_data16;
    logic        active16;
    logic [3:0]  ovf16;
    logic        rd_valid8;
    logic [7:0]  rd_data8;
    logic        active8;
    logic [4:0]  ovf8;

    int n_tests = 0;
    int n_fail  = 0;

    hls_module_status_monitor #(.N_CH(4), .CNT_W(16), .CONT_EN(4'b0010)) dut16 (
        .clock(clock), .reset(reset), .finish(finish), .clear(clear),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .rd_en(rd_en), .rd_ch(rd_ch[1:0]), .rd_sel(rd_sel),
        .rd_valid(rd_valid16), .rd_data(rd_data16), .active(active16), .ovf(ovf16)
    );

    hls_module_status_monitor #(.N_CH(5), .CNT_W(8), .CONT_EN(5'b00010)) dut8 (
        .clock(clock), .reset(reset), .finish(finish), .clear(clear),
        .ap_start({1'b0, ap_start}), .ap_ready({1'b0, ap_ready}), .ap_done({1'b0, ap_done}),
        .ap_continue({1'b0, ap_continue}),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
        .rd_valid(rd_valid8), .rd_data(rd_data8), .active(active8), .ovf(ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One read: rd_en for a single edge, then valid and data checked right after that edge
    task automatic rd_chk(input int ch, input int sel, input longint exp, input string tag, input bit use8);
        rd_en  = 1'b1;
        rd_ch  = 3'(ch);
        rd_sel = 3'(sel);
        tick();
        rd_en = 1'b0;
        if (use8) begin
            check({tag, " valid"}, 64'(rd_valid8), 64'd1);
            check(tag, 64'(rd_data8), 64'(exp));
        end else begin
            check({tag, " valid"}, 64'(rd_valid16), 64'd1);
            check(tag, 64'(rd_data16), 64'(exp));
        end
    endtask

    initial begin
        reset       = 1'b0;
        finish      = 1'b0;
        clear       = 1'b0;
        ap_start    = '0;
        ap_ready    = '0;
        ap_done     = '0;
        ap_continue = '0;
        rd_en       = 1'b0;
        rd_ch       = '0;
        rd_sel      = '0;
        #12;
        check("reset ovf", 64'(ovf16), 64'd0);
        check("reset rd_valid", 64'(rd_valid16), 64'd0);
        check("reset rd_data", 64'(rd_data16), 64'd0);
        reset = 1'b1;
        tick();
        check("active after release", 64'(active16), 64'd1);

        // Reset readback: everything zero except {ovf, active} = 1
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 8; s++) begin
                rd_chk(c, s, (s == 7) ? 1 : 0, $sformatf("rst c%0d s%0d", c, s), 1'b0);
            end
        end
        tick();
        check("rd_valid drops", 64'(rd_valid16), 64'd0);

        // Single transaction on ch2: start, done five cycles later
        ap_start[2] = 1'b1;
        tick();
        ap_start[2] = 1'b0;
        repeat (4) tick();
        ap_done[2] = 1'b1;
        tick();
        ap_done[2] = 1'b0;
        rd_chk(2, 0, 1, "ch2 start", 1'b0);
        rd_chk(2, 2, 1, "ch2 done", 1'b0);
        rd_chk(2, 3, 5, "ch2 busy", 1'b0);
        rd_chk(2, 5, 6, "ch2 max_lat", 1'b0);
        rd_chk(2, 4, 0, "ch2 stall", 1'b0);
        rd_chk(2, 6, 0, "ch2 state", 1'b0);

        // Continue stall on ch1: one busy cycle, done with continue low, three stall cycles
        ap_start[1] = 1'b1;
        tick();
        ap_start[1] = 1'b0;
        ap_done[1]  = 1'b1;
        tick();
        ap_done[1]  = 1'b0;
        ap_start[1] = 1'b1;
        rd_chk(1, 6, 2, "ch1 hold state", 1'b0);
        ap_start[1] = 1'b0;
        repeat (2) tick();
        ap_continue[1] = 1'b1;
        tick();
        ap_continue[1] = 1'b0;
        rd_chk(1, 4, 3, "ch1 stall", 1'b0);
        rd_chk(1, 6, 0, "ch1 state after", 1'b0);
        rd_chk(1, 0, 1, "ch1 start", 1'b0);
        rd_chk(1, 2, 1, "ch1 done", 1'b0);
        rd_chk(1, 3, 1, "ch1 busy", 1'b0);
        rd_chk(1, 5, 2, "ch1 max_lat", 1'b0);

        // Zero-latency module on ch0
        ap_start[0] = 1'b1;
        ap_done[0]  = 1'b1;
        ap_ready[0] = 1'b1;
        repeat (4) tick();
        ap_start[0] = 1'b0;
        ap_done[0]  = 1'b0;
        ap_ready[0] = 1'b0;
        rd_chk(0, 0, 4, "ch0 start", 1'b0);
        rd_chk(0, 2, 4, "ch0 done", 1'b0);
        rd_chk(0, 1, 4, "ch0 ready", 1'b0);
        rd_chk(0, 3, 0, "ch0 busy", 1'b0);
        rd_chk(0, 5, 1, "ch0 max_lat", 1'b0);

        // Window closed: ch3 activity tracked by the FSM but not counted
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("active after finish", 64'(active16), 64'd0);
        ap_start[3] = 1'b1;
        tick();
        ap_start[3] = 1'b0;
        rd_chk(3, 6, 1, "ch3 busy state frozen win", 1'b0);
        ap_done[3] = 1'b1;
        tick();
        ap_done[3] = 1'b0;
        for (int t = 0; t < 9; t++) begin
            ap_start[3] = 1'b1;
            tick();
            ap_start[3] = 1'b0;
            ap_done[3]  = 1'b1;
            tick();
            ap_done[3]  = 1'b0;
        end
        rd_chk(3, 0, 0, "ch3 start frozen", 1'b0);
        rd_chk(3, 2, 0, "ch3 done frozen", 1'b0);
        rd_chk(3, 3, 0, "ch3 busy frozen", 1'b0);
        rd_chk(3, 7, 0, "ch3 ovf/active", 1'b0);
        rd_chk(0, 0, 4, "ch0 start kept", 1'b0);
        check("still inactive", 64'(active16), 64'd0);

        // clear wins over finish
        clear  = 1'b1;
        finish = 1'b1;
        tick();
        clear  = 1'b0;
        finish = 1'b0;
        check("active after clear", 64'(active16), 64'd1);
        rd_chk(0, 0, 0, "ch0 start cleared", 1'b0);
        rd_chk(2, 3, 0, "ch2 busy cleared", 1'b0);
        rd_chk(1, 4, 0, "ch1 stall cleared", 1'b0);
        rd_chk(0, 5, 0, "ch0 max_lat cleared", 1'b0);
        rd_chk(0, 7, 1, "ch0 ovf/active cleared", 1'b0);
        check("ovf cleared", 64'(ovf16), 64'd0);

        // Saturation: ch0 busy for 300 cycles
        ap_start[0] = 1'b1;
        tick();
        ap_start[0] = 1'b0;
        repeat (299) tick();
        ap_done[0] = 1'b1;
        tick();
        ap_done[0] = 1'b0;
        check("ovf8", 64'(ovf8), 64'd1);
        check("ovf16", 64'(ovf16), 64'd0);
        rd_chk(0, 3, 255, "sat busy8", 1'b1);
        rd_chk(0, 3, 300, "busy16", 1'b0);
        rd_chk(0, 5, 255, "sat max_lat8", 1'b1);
        rd_chk(0, 5, 301, "max_lat16", 1'b0);
        rd_chk(0, 7, 3, "ch0 ovf/active8", 1'b1);
        rd_chk(1, 7, 1, "ch1 ovf/active8", 1'b1);
        rd_chk(0, 2, 1, "ch0 done8", 1'b1);
        rd_chk(5, 0, 0, "out-of-range ch", 1'b1);
        rd_chk(7, 7, 0, "out-of-range ch7", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_module_status_monitor.md
Name: hls_module_status_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only per-module status monitor.
- Observes the ap_start/ap_ready/ap_done/ap_continue block-level handshake of up to N_CH HLS submodules, e.g. the decision_function instances under the myproject wrapper.
- Per channel: tracks a 3-state activity FSM and accumulates saturating start/ready/done/busy/stall counts and max observed latency over a measurement window closed by finish.
- Results are read back over a registered select-and-read port, replacing the CSV dump.

Parameters:
N_CH, 10, number of monitored module channels (1..32)
CNT_W, 32, width of every counter and of rd_data (8..64)
CONT_EN, {N_CH{1'b0}}, per-channel mask; bit=1: ap_continue is honoured (HOLD state used); bit=0: ap_continue treated as constant 1

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
finish  in  1  end of measurement window; sticky once sampled high
clear  in  1  synchronous pulse; zeroes all statistics and reopens the window
ap_start  in  N_CH  per-channel ap_start
ap_ready  in  N_CH  per-channel ap_ready
ap_done  in  N_CH  per-channel ap_done
ap_continue  in  N_CH  per-channel ap_continue (ignored where CONT_EN bit=0)
rd_en  in  1  read request
rd_ch  in  $clog2(N_CH) (min 1)  channel to read
rd_sel  in  3  statistic select
rd_valid  out  1  rd_data valid, one cycle after rd_en
rd_data  out  CNT_W  selected statistic
active  out  1  measurement window open
ovf  out  N_CH  sticky per-channel saturation flag

Behaviour:
- Reset (reset=0, async):
  - All counters, ovf, rd_valid and rd_data = 0.
  - All channel FSMs = IDLE.
  - active = 1 on the first clock edge after reset release.
- Window:
  - active clears on the edge where finish=1 and stays 0 until clear.
  - While active=0, counters and max_lat are frozen; FSMs keep tracking state.
  - clear has priority over finish in the same cycle: counters, max_lat and ovf zeroed, active=1, finish ignored that cycle.
  - FSM states are not reset by clear.
- Channel FSM (per channel; counter updates only when active=1):
  - IDLE:
    - ap_start=1: start_cnt++, lat=1.
    - If ap_done=1 in the same cycle: done_cnt++, max_lat=max(max_lat,1), next state HOLD if (CONT_EN bit & ~ap_continue), else IDLE.
    - Otherwise next state BUSY.
  - BUSY:
    - Each cycle: busy_cnt++, lat++.
    - On ap_done=1: done_cnt++, max_lat=max(max_lat, lat+1), next state HOLD if (CONT_EN bit & ~ap_continue), else IDLE.
  - HOLD:
    - stall_cnt++ each cycle while ap_continue=0.
    - ap_continue=1: next state IDLE; no stall count that cycle.
  - ready_cnt++ on every cycle ap_ready=1, independent of state.
  - ap_start while BUSY/HOLD: ignored, not counted.
  - ap_done while IDLE without ap_start: ignored.
- Saturation:
  - Every counter and lat saturates at 2^CNT_W-1 instead of wrapping.
  - Any saturating increment sets ovf[ch]; ovf is cleared only by reset or clear.
- Readback:
  - rd_en=1 at edge k: rd_valid=1 and rd_data valid at edge k+1; rd_valid=0 otherwise; rd_data holds its last value.
  - Data is sampled after the same-edge update, i.e. reflects counts through cycle k-1.
  - rd_sel: 0 start_cnt, 1 ready_cnt, 2 done_cnt, 3 busy_cnt, 4 stall_cnt, 5 max_lat, 6 FSM state (IDLE=0, BUSY=1, HOLD=2) zero-extended, 7 {ovf[ch], active} zero-extended.
  - rd_ch >= N_CH: rd_data=0, rd_valid still 1.
- Channels are fully independent; simultaneous events on all channels are all counted in the same cycle.

Test Plan:
- Reset/readback: N_CH=4, CNT_W=16. Release reset, read all 4 ch × 8 sel → all 0 except sel6=0 and sel7=1 (active). rd_valid exactly one cycle after each rd_en.
- Single transaction: ch2 ap_start 1 cycle, ap_done 5 cycles later, CONT_EN=0 → start=1, done=1, busy=5, max_lat=6, stall=0, state=IDLE.
- Continue stall: CONT_EN[1]=1, ch1 completes with ap_continue low for 3 cycles then high → stall=3, state HOLD (2) read mid-stall, IDLE after. An ap_start during HOLD is not counted.
- Zero-latency combinational module: ch0 ap_start=ap_done=ap_ready=1 for 4 consecutive cycles → start=4, done=4, ready=4, busy=0, max_lat=1.
- Window/clear: pulse finish, run 10 more transactions on ch3 → counts unchanged, active=0. Assert clear and finish together → all stats 0, active=1.
- Saturation: CNT_W=8, hold ch0 busy 300 cycles → busy_cnt=255, ovf[0]=1; ovf[1..3]=0. rd_ch=5 → rd_data=0.
